// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - raw button inputs and conditioned level/tick outputs
interface btn_debounce_if #(
  parameter int N = 3
);
  logic [N-1:0] btn_raw;
  logic [N-1:0] db_level;
  logic [N-1:0] rise_tick;
  logic [N-1:0] fall_tick;

  modport master (output btn_raw, input db_level, rise_tick, fall_tick);
  modport slave  (input btn_raw, output db_level, rise_tick, fall_tick);
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-channel synchroniser, bounce qualifier and edge ticks
module btn_debounce #(
  parameter int N     = 3,
  parameter int CNT_W = 20
) (
  input  logic           clk,
  input  logic           reset,
  btn_debounce_if.slave  bus
);
  localparam logic [1:0] ZERO  = 2'd0;
  localparam logic [1:0] WAIT1 = 2'd1;
  localparam logic [1:0] ONE   = 2'd2;
  localparam logic [1:0] WAIT0 = 2'd3;

  localparam logic [CNT_W-1:0] M     = '1;
  localparam logic [CNT_W-1:0] DEC_1 = {{(CNT_W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic             s1_q, s2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Outputs are computed from the next state so they line up with the state register.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        ZERO: begin
          if (s2_q) begin
            state_d = WAIT1;
            cnt_d   = M;
          end
        end
        WAIT1: begin
          if (!s2_q) begin
            state_d = ZERO;
          end else if (cnt_q == '0) begin
            state_d = ONE;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - DEC_1;
          end
        end
        ONE: begin
          if (!s2_q) begin
            state_d = WAIT0;
            cnt_d   = M;
          end
        end
        WAIT0: begin
          if (s2_q) begin
            state_d = ONE;
          end else if (cnt_q == '0) begin
            state_d = ZERO;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - DEC_1;
          end
        end
        default: state_d = ZERO;
      endcase
      db_d = (state_d == ONE) || (state_d == WAIT0);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        state_q <= ZERO;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        s1_q    <= bus.btn_raw[i];
        s2_q    <= s1_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign bus.db_level[i]  = db_q;
    assign bus.rise_tick[i] = rise_q;
    assign bus.fall_tick[i] = fall_q;
  end
endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - scoreboard bench for btn_debounce
module tb_btn_debounce;
  localparam int N     = 3;
  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  btn_debounce_if #(.N(N)) bus ();

  btn_debounce #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  id;
    logic [2:0]  db;
    logic [2:0]  rise;
    logic [2:0]  fall;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc    = 0;
  int          passed = 0;
  int          total  = 0;
  bit          done   = 1'b0;
  logic [7:0]  ev_id  = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int unsigned c, input logic [2:0] db,
                           input logic [2:0] r, input logic [2:0] f);
    sb.push_back('{cyc: c, id: ev_id, db: db, rise: r, fall: f});
    ev_id = ev_id + 8'd1;
  endtask

  task automatic level(input logic [2:0] db);
    expect_at(cyc + 1, db, 3'b000, 3'b000);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void chk(input string what, input logic [7:0] id,
                              input logic [2:0] act, input logic [2:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL ev%0d %s at cycle %0d: got %b expected %b", id, what, cyc, act, exp_v);
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      total++;
      $display("FAIL ev%0d missed: due at cycle %0d, now %0d", e.id, e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("db_level", e.id, bus.db_level, e.db);
      chk("rise_tick", e.id, bus.rise_tick, e.rise);
      chk("fall_tick", e.id, bus.fall_tick, e.fall);
    end else if ((|bus.rise_tick) || (|bus.fall_tick)) begin
      total++;
      $display("FAIL unexpected_tick at cycle %0d: rise %b fall %b expected none",
               cyc, bus.rise_tick, bus.fall_tick);
    end
    if (done) begin
      total++;
      if (sb.size() == 0) passed++;
      else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.btn_raw = 3'b000;
    reset       = 1'b1;
    for (int c = 1; c <= 3; c++) expect_at(c, 3'b000, 3'b000, 3'b000);
    step(3);
    reset = 1'b0;
    expect_at(cyc + 50, 3'b000, 3'b000, 3'b000);
    step(50);

    // clean press and release on ch0
    bus.btn_raw = 3'b001;
    expect_at(cyc + 19, 3'b001, 3'b001, 3'b000);
    step(25);
    level(3'b001);
    bus.btn_raw = 3'b000;
    expect_at(cyc + 19, 3'b000, 3'b000, 3'b001);
    step(25);

    // ch1 bounces every 5 cycles, then settles high
    for (int s = 0; s < 8; s++) begin
      bus.btn_raw[1] = (s % 2 == 0);
      step(5);
    end
    bus.btn_raw[1] = 1'b1;
    expect_at(cyc + 19, 3'b010, 3'b010, 3'b000);
    step(25);
    level(3'b010);

    // ch2 qualified high, short low glitch, then real release
    bus.btn_raw = 3'b110;
    expect_at(cyc + 19, 3'b110, 3'b100, 3'b000);
    step(25);
    level(3'b110);
    bus.btn_raw = 3'b010;
    step(3);
    bus.btn_raw = 3'b110;
    step(25);
    level(3'b110);
    bus.btn_raw = 3'b010;
    expect_at(cyc + 19, 3'b010, 3'b000, 3'b100);
    step(25);
    level(3'b010);
    bus.btn_raw = 3'b000;
    expect_at(cyc + 19, 3'b000, 3'b000, 3'b010);
    step(25);

    // reset one cycle in the middle of a ch0 qualification
    bus.btn_raw = 3'b001;
    step(10);
    reset = 1'b1;
    step(1);
    expect_at(cyc, 3'b000, 3'b000, 3'b000);
    reset = 1'b0;
    expect_at(cyc + 19, 3'b001, 3'b001, 3'b000);
    step(25);
    level(3'b001);
    bus.btn_raw = 3'b000;
    expect_at(cyc + 19, 3'b000, 3'b000, 3'b001);
    step(25);

    // all channels together
    bus.btn_raw = 3'b111;
    expect_at(cyc + 19, 3'b111, 3'b111, 3'b000);
    step(25);
    level(3'b111);
    bus.btn_raw = 3'b000;
    expect_at(cyc + 19, 3'b000, 3'b000, 3'b111);
    step(25);

    done = 1'b1;
    step(4);
  end
endmodule
